// File: rtl/bl_fade_timeout_if.sv
// bl_fade_timeout_if
// Groups the backlight controller's control inputs and status outputs.
//   master : drives bl_on, bl_time, bl_level, event_tgl, hold; observes status
//   slave  : the controller; consumes controls, drives bl_pwm, bl_duty,
//            timed_out, bl_state, idle_ms
interface bl_fade_timeout_if #(
    parameter int N_EVENTS = 2,
    parameter int MS_W     = 15,
    parameter int PWM_W    = 8
);
    logic                bl_on;
    logic [1:0]          bl_time;
    logic [PWM_W-1:0]    bl_level;
    logic [N_EVENTS-1:0] event_tgl;
    logic                hold;
    logic                bl_pwm;
    logic [PWM_W-1:0]    bl_duty;
    logic                timed_out;
    logic [1:0]          bl_state;
    logic [MS_W-1:0]     idle_ms;

    modport master (
        output bl_on, bl_time, bl_level, event_tgl, hold,
        input  bl_pwm, bl_duty, timed_out, bl_state, idle_ms
    );

    modport slave (
        input  bl_on, bl_time, bl_level, event_tgl, hold,
        output bl_pwm, bl_duty, timed_out, bl_state, idle_ms
    );
endinterface

// File: rtl/bl_fade_timeout.sv
// bl_fade_timeout
// Activity timeout and backlight controller for the front-panel LCD.
// Counts idle milliseconds since the last toggle on any activity input and,
// once the selected timeout expires, fades the PWM backlight linearly to zero
// before going dark.
//
// Ports:
//   clk27  : system clock
//   reset  : asynchronous, active-high reset
//   bus    : bl_fade_timeout_if.slave
//            in  bl_on, bl_time[1:0], bl_level, event_tgl, hold
//            out bl_pwm, bl_duty, timed_out, bl_state[1:0], idle_ms
//
// state | meaning
// ------+------------------------------------------------------------
// DIS   | backlight disabled by bl_on = 0, duty 0
// ON    | duty follows bl_level, waiting for idle timeout
// FADE  | duty ramps down by 1 every FADE_DIV cycles
// DARK  | timed out, duty 0, waiting for activity / hold / never-timeout
module bl_fade_timeout #(
    parameter int CLK_FREQ_HZ = 27000000,
    parameter int N_EVENTS    = 2,
    parameter int MS_W        = 15,
    parameter int T1_MS       = 3000,
    parameter int T2_MS       = 10000,
    parameter int T3_MS       = 30000,
    parameter int FADE_MS     = 500,
    parameter int PWM_W       = 8
) (
    input  logic clk27,
    input  logic reset,
    bl_fade_timeout_if.slave bus
);
    localparam int P            = CLK_FREQ_HZ / 1000;
    localparam int FULL         = (2 ** PWM_W) - 1;
    localparam int FADE_DIV_RAW = (P * FADE_MS) / FULL;
    localparam int FADE_DIV     = (FADE_DIV_RAW < 1) ? 1 : FADE_DIV_RAW;
    localparam int TICK_W       = (P > 1) ? $clog2(P) : 1;
    localparam int FADE_W       = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    typedef enum logic [1:0] {
        ST_DIS  = 2'b00,
        ST_ON   = 2'b01,
        ST_FADE = 2'b10,
        ST_DARK = 2'b11
    } state_t;

    state_t              state;
    logic [N_EVENTS-1:0] event_prev;
    logic [TICK_W-1:0]   tick_ctr;
    logic [MS_W-1:0]     idle_ms_q;
    logic [FADE_W-1:0]   fade_ctr;
    logic [PWM_W-1:0]    duty;
    logic [PWM_W-1:0]    pwm_ctr;
    logic                pwm_q;
    logic                timed_out_q;

    logic                evt;
    logic                tick;
    logic                expired;
    logic [31:0]         thr;

    assign evt  = |(bus.event_tgl ^ event_prev);
    assign tick = (tick_ctr == TICK_W'(P - 1));

    always_comb begin
        thr = 32'd0;
        case (bus.bl_time)
            2'b01:   thr = 32'(T1_MS);
            2'b10:   thr = 32'(T2_MS);
            2'b11:   thr = 32'(T3_MS);
            default: thr = 32'd0;
        endcase
    end

    // Compare at 32 bits so presets larger than the idle counter simply never expire.
    assign expired = (bus.bl_time != 2'b00) && (32'(idle_ms_q) >= thr);

    // Millisecond prescaler and saturating idle counter; activity wins over a tick.
    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            event_prev <= '0;
            tick_ctr   <= '0;
            idle_ms_q  <= '0;
        end else begin
            event_prev <= bus.event_tgl;
            if (evt) begin
                tick_ctr  <= '0;
                idle_ms_q <= '0;
            end else begin
                if (tick) tick_ctr <= '0;
                else      tick_ctr <= tick_ctr + TICK_W'(1);
                if (tick && (idle_ms_q != {MS_W{1'b1}}))
                    idle_ms_q <= idle_ms_q + MS_W'(1);
            end
        end
    end

    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            state       <= ST_DIS;
            duty        <= '0;
            fade_ctr    <= '0;
            timed_out_q <= 1'b0;
        end else if (!bus.bl_on) begin
            state       <= ST_DIS;
            duty        <= '0;
            fade_ctr    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            case (state)
                ST_DIS: begin
                    state       <= ST_ON;
                    duty        <= bus.bl_level;
                    fade_ctr    <= '0;
                    timed_out_q <= 1'b0;
                end
                ST_ON: begin
                    duty        <= bus.bl_level;
                    fade_ctr    <= '0;
                    timed_out_q <= 1'b0;
                    if (expired && !bus.hold && !evt)
                        state <= ST_FADE;
                end
                ST_FADE, ST_DARK: begin
                    if (evt || bus.hold || (bus.bl_time == 2'b00)) begin
                        state       <= ST_ON;
                        duty        <= bus.bl_level;
                        fade_ctr    <= '0;
                        timed_out_q <= 1'b0;
                    end else if (state == ST_DARK) begin
                        duty        <= '0;
                        timed_out_q <= 1'b1;
                    end else if (duty == '0) begin
                        state       <= ST_DARK;
                        fade_ctr    <= '0;
                        timed_out_q <= 1'b1;
                    end else if (fade_ctr == FADE_W'(FADE_DIV - 1)) begin
                        fade_ctr <= '0;
                        duty     <= duty - PWM_W'(1);
                    end else begin
                        fade_ctr <= fade_ctr + FADE_W'(1);
                    end
                end
                default: begin
                    state       <= ST_DIS;
                    duty        <= '0;
                    fade_ctr    <= '0;
                    timed_out_q <= 1'b0;
                end
            endcase
        end
    end

    // PWM period is FULL cycles so duty FULL is solid high and duty 0 solid low.
    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            pwm_ctr <= '0;
            pwm_q   <= 1'b0;
        end else begin
            if (pwm_ctr == PWM_W'(FULL - 1)) pwm_ctr <= '0;
            else                             pwm_ctr <= pwm_ctr + PWM_W'(1);
            pwm_q <= (pwm_ctr < duty);
        end
    end

    assign bus.bl_pwm    = pwm_q;
    assign bus.bl_duty   = duty;
    assign bus.timed_out = timed_out_q;
    assign bus.bl_state  = state;
    assign bus.idle_ms   = idle_ms_q;
endmodule

// File: tb/tb_bl_fade_timeout.sv
module tb_bl_fade_timeout;
    localparam int N_EVENTS = 2;
    localparam int MS_W     = 4;
    localparam int PWM_W    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   npass = 0;
    int   ntotal = 0;

    bl_fade_timeout_if #(.N_EVENTS(N_EVENTS), .MS_W(MS_W), .PWM_W(PWM_W)) bus ();

    bl_fade_timeout #(
        .CLK_FREQ_HZ(10000),
        .N_EVENTS   (N_EVENTS),
        .MS_W       (MS_W),
        .T1_MS      (5),
        .T2_MS      (8),
        .T3_MS      (12),
        .FADE_MS    (3),
        .PWM_W      (PWM_W)
    ) dut (
        .clk27(clk),
        .reset(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
    endtask

    // Advance to edge e (counted from the last reset release), sample 1 time unit later.
    task automatic goto(input int e);
        while (cyc < e) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    initial begin
        int bad;
        int highs;

        bus.bl_on     = 1'b0;
        bus.bl_time   = 2'b00;
        bus.bl_level  = 4'd15;
        bus.event_tgl = 2'b00;
        bus.hold      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(bus.bl_state), 32'd0);
        chk("rst_duty", 32'(bus.bl_duty), 32'd0);
        chk("rst_pwm", 32'(bus.bl_pwm), 32'd0);
        chk("rst_idle", 32'(bus.idle_ms), 32'd0);
        chk("rst_tout", 32'(bus.timed_out), 32'd0);

        bus.bl_on   = 1'b1;
        bus.bl_time = 2'b01;
        rst = 1'b0;
        cyc = 0;

        goto(1);
        chk("on_state", 32'(bus.bl_state), 32'd1);
        chk("on_duty", 32'(bus.bl_duty), 32'd15);
        bad = 0;
        for (int e = 2; e <= 17; e++) begin
            goto(e);
            if (bus.bl_pwm !== 1'b1) bad++;
        end
        chk("pwm_full_const_high", 32'(bad), 32'd0);

        goto(10);
        chk("idle_first_tick", 32'(bus.idle_ms), 32'd1);
        goto(49);
        chk("idle_49", 32'(bus.idle_ms), 32'd4);
        goto(50);
        chk("idle_50", 32'(bus.idle_ms), 32'd5);
        chk("state_50_on", 32'(bus.bl_state), 32'd1);
        goto(51);
        chk("state_51_fade", 32'(bus.bl_state), 32'd2);
        chk("duty_51", 32'(bus.bl_duty), 32'd15);
        bad = 0;
        for (int e = 52; e <= 81; e++) begin
            goto(e);
            if (bus.bl_duty !== 4'(15 - (e - 51) / 2)) bad++;
            if (bus.bl_state !== 2'd2) bad++;
        end
        chk("fade_ramp", 32'(bad), 32'd0);
        chk("duty_81_zero", 32'(bus.bl_duty), 32'd0);
        goto(82);
        chk("dark_state", 32'(bus.bl_state), 32'd3);
        chk("dark_tout", 32'(bus.timed_out), 32'd1);

        bus.event_tgl[1] = 1'b1;
        goto(83);
        chk("dark_evt_state", 32'(bus.bl_state), 32'd1);
        chk("dark_evt_duty", 32'(bus.bl_duty), 32'd15);
        chk("dark_evt_idle", 32'(bus.idle_ms), 32'd0);
        chk("dark_evt_tout", 32'(bus.timed_out), 32'd0);

        goto(134);
        chk("fade2_entry", 32'(bus.bl_state), 32'd2);
        goto(150);
        chk("fade2_duty7", 32'(bus.bl_duty), 32'd7);
        bus.event_tgl[1] = 1'b0;
        goto(151);
        chk("fade_evt_state", 32'(bus.bl_state), 32'd1);
        chk("fade_evt_duty", 32'(bus.bl_duty), 32'd15);
        chk("fade_evt_idle", 32'(bus.idle_ms), 32'd0);

        goto(200);
        chk("idle_200", 32'(bus.idle_ms), 32'd4);
        bus.event_tgl[0] = 1'b1;
        goto(201);
        chk("race_idle", 32'(bus.idle_ms), 32'd0);
        chk("race_state", 32'(bus.bl_state), 32'd1);
        goto(202);
        chk("race_state_next", 32'(bus.bl_state), 32'd1);

        bus.hold = 1'b1;
        goto(251);
        chk("hold_idle5", 32'(bus.idle_ms), 32'd5);
        goto(281);
        chk("hold_idle8", 32'(bus.idle_ms), 32'd8);
        chk("hold_state_on", 32'(bus.bl_state), 32'd1);
        bus.hold = 1'b0;
        goto(282);
        chk("hold_release_fade", 32'(bus.bl_state), 32'd2);

        goto(313);
        chk("dark2_state", 32'(bus.bl_state), 32'd3);
        goto(351);
        chk("idle_sat_reach", 32'(bus.idle_ms), 32'd15);
        goto(371);
        chk("idle_sat_hold", 32'(bus.idle_ms), 32'd15);

        bus.event_tgl[1] = 1'b1;
        goto(372);
        chk("wake3_state", 32'(bus.bl_state), 32'd1);
        goto(423);
        chk("fade3_entry", 32'(bus.bl_state), 32'd2);
        goto(425);
        chk("fade3_duty14", 32'(bus.bl_duty), 32'd14);
        bus.bl_on = 1'b0;
        goto(426);
        chk("blon_off_state", 32'(bus.bl_state), 32'd0);
        chk("blon_off_duty", 32'(bus.bl_duty), 32'd0);
        goto(427);
        chk("blon_off_pwm", 32'(bus.bl_pwm), 32'd0);

        bus.bl_on    = 1'b1;
        bus.bl_level = 4'd5;
        bus.bl_time  = 2'b00;
        goto(428);
        chk("lvl5_duty", 32'(bus.bl_duty), 32'd5);
        highs = 0;
        for (int e = 430; e <= 444; e++) begin
            goto(e);
            if (bus.bl_pwm === 1'b1) highs++;
        end
        chk("pwm_duty5_highs", 32'(highs), 32'd5);
        goto(480);
        chk("never_timeout_state", 32'(bus.bl_state), 32'd1);
        chk("never_timeout_idle", 32'(bus.idle_ms), 32'd10);

        bus.bl_level = 4'd15;
        bus.bl_time  = 2'b01;
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_state", 32'(bus.bl_state), 32'd0);
        chk("midrst_duty", 32'(bus.bl_duty), 32'd0);
        chk("midrst_idle", 32'(bus.idle_ms), 32'd0);
        chk("midrst_pwm", 32'(bus.bl_pwm), 32'd0);
        goto(482);
        rst = 1'b0;
        cyc = 0;
        goto(1);
        chk("post_rst_on", 32'(bus.bl_state), 32'd1);
        chk("post_rst_duty", 32'(bus.bl_duty), 32'd15);
        goto(10);
        chk("post_rst_evt_idle10", 32'(bus.idle_ms), 32'd0);
        goto(11);
        chk("post_rst_evt_idle11", 32'(bus.idle_ms), 32'd1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
